// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: deserialises frames, strips F0/E0 prefixes, strobes key events.
// Optional typematic repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       strobe,
  output logic       pressed,
  output logic       extended,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  // Stage p0/p1: two-flop synchronisers; lines idle high
  logic clk_p0, clk_p1, dat_p0, dat_p1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_dat;
      dat_p1 <= dat_p0;
    end
  end

  // Glitch filter: level flips only after FILTER_LEN consecutive opposite samples
  logic           filt_clk;
  logic [FCW-1:0] filt_cnt;
  logic           fall;

  assign fall = filt_clk && !clk_p1 && (filt_cnt == FCW'(FILTER_LEN - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_p1 != filt_clk) begin
      if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Frame FSM and byte handling; accepted bytes are decoded on the stop-bit fall edge
  logic [1:0]     state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par;
  logic [TCW-1:0] tcnt;
  logic           brk, ext;
  logic [2:0]     skip;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic           rpt_vld;
  logic           rpt_ext;
  logic [7:0]     rpt_code;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      skip      <= '0;
      code      <= '0;
      strobe    <= 1'b0;
      pressed   <= 1'b0;
      extended  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      rpt_vld   <= 1'b0;
      rpt_ext   <= 1'b0;
      rpt_code  <= '0;
`endif
    end else begin
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_p1) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {dat_p1, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_p1;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (dat_p1 && parity_ok(shreg, par)) begin
              if (skip != 3'd0) begin
                skip <= skip - 3'd1;
              end else if (shreg == 8'hE1) begin
                skip <= 3'd7;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (!is_ignored(shreg)) begin
                brk <= 1'b0;
                ext <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (brk || !rpt_vld || ({ext, shreg} != {rpt_ext, rpt_code})) begin
                  strobe   <= 1'b1;
                  code     <= shreg;
                  pressed  <= ~brk;
                  extended <= ext;
                  rpt_vld  <= ~brk;
                  rpt_ext  <= ext;
                  rpt_code <= shreg;
                end
`else
                strobe   <= 1'b1;
                code     <= shreg;
                pressed  <= ~brk;
                extended <= ext;
`endif
              end
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b0;
              ext       <= 1'b0;
              skip      <= '0;
            end
          end
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TCW'(TIMEOUT - 1)) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
